// File: rtl/memory_request_sequencer.sv
// Arbitrates instruction fetches against loads/stores, range/alignment-checks
// the winner and runs a single-word memory cycle, answering with a one-cycle ack.
module memory_request_sequencer #(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    MEMORY_DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] INSTRUCTION_RANGE = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] DATA_RANGE        = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Fetch_Req_i,
    input  logic [DATA_WIDTH-1:0] Fetch_Addr_i,
    output logic                  Fetch_Ack_o,
    output logic [DATA_WIDTH-1:0] Instruction_o,
    input  logic                  Data_Req_i,
    input  logic                  Data_Write_i,
    input  logic [DATA_WIDTH-1:0] Data_Addr_i,
    input  logic [DATA_WIDTH-1:0] Data_Wdata_i,
    output logic                  Data_Ack_o,
    output logic [DATA_WIDTH-1:0] Data_Rdata_o,
    output logic                  Fault_o,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    output logic                  Mem_Write_Enable_o,
    output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic       CH_FETCH = 1'b0;
    localparam logic       CH_DATA  = 1'b1;

    // Window limits carry one extra bit so the upper bound never wraps.
    localparam logic [DATA_WIDTH:0] WIN_BYTES = (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH:0] ROM_LO    = {1'b0, INSTRUCTION_RANGE};
    localparam logic [DATA_WIDTH:0] ROM_HI    = ROM_LO + WIN_BYTES;
    localparam logic [DATA_WIDTH:0] RAM_LO    = {1'b0, DATA_RANGE};
    localparam logic [DATA_WIDTH:0] RAM_HI    = RAM_LO + WIN_BYTES;

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  chan_q, chan_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  fetch_ack_q, fetch_ack_d;
    logic                  data_ack_q, data_ack_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] drdata_q, drdata_d;

    logic                  grant_any_s;
    logic                  grant_data_s;
    logic                  sel_write_s;
    logic [DATA_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH:0]   addr_ext_s;
    logic                  in_rom_s;
    logic                  in_ram_s;
    logic                  fault_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Arbitration and fault classification of the request that would be granted now.
    always_comb begin
        grant_any_s  = Fetch_Req_i | Data_Req_i;
        grant_data_s = Data_Req_i & (~Fetch_Req_i | (last_grant_q == CH_FETCH));
        sel_addr_s   = grant_data_s ? Data_Addr_i : Fetch_Addr_i;
        sel_write_s  = grant_data_s & Data_Write_i;
        addr_ext_s   = {1'b0, sel_addr_s};
        in_rom_s     = (addr_ext_s >= ROM_LO) && (addr_ext_s < ROM_HI);
        in_ram_s     = (addr_ext_s >= RAM_LO) && (addr_ext_s < RAM_HI);
        if (sel_addr_s[1:0] != 2'b00) begin
            fault_s = 1'b1;
        end else if (grant_data_s) begin
            fault_s = ~in_ram_s | (sel_write_s & in_rom_s);
        end else begin
            fault_s = ~in_rom_s;
        end
    end

    // Next-state logic for the IDLE/ACCESS/RESP sequencer and its registered outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        chan_d       = chan_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        fetch_ack_d  = 1'b0;
        data_ack_d   = 1'b0;
        fault_d      = 1'b0;
        instr_d      = instr_q;
        drdata_d     = drdata_q;
        rd_word_s    = write_q ? {DATA_WIDTH{1'b0}} : Mem_Read_Data_i;
        case (state_q)
            S_IDLE: begin
                if (grant_any_s) begin
                    chan_d  = grant_data_s;
                    write_d = sel_write_s;
                    addr_d  = sel_addr_s;
                    wdata_d = grant_data_s ? Data_Wdata_i : wdata_q;
                    if (fault_s) begin
                        // Faults skip the memory cycle and answer straight away with zero data.
                        state_d     = S_RESP;
                        fault_d     = 1'b1;
                        fetch_ack_d = ~grant_data_s;
                        data_ack_d  = grant_data_s;
                        if (grant_data_s) begin
                            drdata_d = {DATA_WIDTH{1'b0}};
                        end else begin
                            instr_d = {DATA_WIDTH{1'b0}};
                        end
                    end else begin
                        state_d = S_ACCESS;
                        we_d    = sel_write_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (chan_q == CH_DATA) begin
                    data_ack_d = 1'b1;
                    drdata_d   = rd_word_s;
                end else begin
                    fetch_ack_d = 1'b1;
                    instr_d     = rd_word_s;
                end
            end
            S_RESP: begin
                state_d      = S_IDLE;
                last_grant_d = chan_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= CH_DATA;
            chan_q       <= CH_FETCH;
            write_q      <= 1'b0;
            addr_q       <= {DATA_WIDTH{1'b0}};
            wdata_q      <= {DATA_WIDTH{1'b0}};
            we_q         <= 1'b0;
            fetch_ack_q  <= 1'b0;
            data_ack_q   <= 1'b0;
            fault_q      <= 1'b0;
            instr_q      <= {DATA_WIDTH{1'b0}};
            drdata_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            chan_q       <= chan_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            fetch_ack_q  <= fetch_ack_d;
            data_ack_q   <= data_ack_d;
            fault_q      <= fault_d;
            instr_q      <= instr_d;
            drdata_q     <= drdata_d;
        end
    end

    assign Fetch_Ack_o        = fetch_ack_q;
    assign Instruction_o      = instr_q;
    assign Data_Ack_o         = data_ack_q;
    assign Data_Rdata_o       = drdata_q;
    assign Fault_o            = fault_q;
    assign Mem_Address_o      = addr_q;
    assign Mem_Write_Enable_o = we_q;
    assign Mem_Write_Data_o   = wdata_q;

endmodule

// File: tb/tb_memory_request_sequencer.sv
// Directed bench for memory_request_sequencer with a small ROM/RAM model
// answering the memory port.
module tb_memory_request_sequencer;

    logic        clk;
    logic        reset;
    logic        Fetch_Req_i;
    logic [31:0] Fetch_Addr_i;
    logic        Fetch_Ack_o;
    logic [31:0] Instruction_o;
    logic        Data_Req_i;
    logic        Data_Write_i;
    logic [31:0] Data_Addr_i;
    logic [31:0] Data_Wdata_i;
    logic        Data_Ack_o;
    logic [31:0] Data_Rdata_o;
    logic        Fault_o;
    logic [31:0] Mem_Address_o;
    logic        Mem_Write_Enable_o;
    logic [31:0] Mem_Write_Data_o;
    logic [31:0] Mem_Read_Data_i;

    logic [31:0] rom [64];
    logic [31:0] ram [64];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          we_cnt = 0;

    memory_request_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .Fetch_Req_i        (Fetch_Req_i),
        .Fetch_Addr_i       (Fetch_Addr_i),
        .Fetch_Ack_o        (Fetch_Ack_o),
        .Instruction_o      (Instruction_o),
        .Data_Req_i         (Data_Req_i),
        .Data_Write_i       (Data_Write_i),
        .Data_Addr_i        (Data_Addr_i),
        .Data_Wdata_i       (Data_Wdata_i),
        .Data_Ack_o         (Data_Ack_o),
        .Data_Rdata_o       (Data_Rdata_o),
        .Fault_o            (Fault_o),
        .Mem_Address_o      (Mem_Address_o),
        .Mem_Write_Enable_o (Mem_Write_Enable_o),
        .Mem_Write_Data_o   (Mem_Write_Data_o),
        .Mem_Read_Data_i    (Mem_Read_Data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the clock edge.
    always_comb begin
        if (Mem_Address_o >= 32'h0040_0000 && Mem_Address_o < 32'h0040_0100) begin
            Mem_Read_Data_i = rom[Mem_Address_o[7:2]];
        end else if (Mem_Address_o >= 32'h1001_0000 && Mem_Address_o < 32'h1001_0100) begin
            Mem_Read_Data_i = ram[Mem_Address_o[7:2]];
        end else begin
            Mem_Read_Data_i = 32'h0;
        end
    end

    always @(posedge clk) begin
        if (Mem_Write_Enable_o) begin
            we_cnt <= we_cnt + 1;
            if (Mem_Address_o >= 32'h1001_0000 && Mem_Address_o < 32'h1001_0100) begin
                ram[Mem_Address_o[7:2]] <= Mem_Write_Data_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request on one channel, checked through to the end of its ack.
    task automatic req_op(input string tag, input logic is_data, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic flt, input logic [31:0] exp_rd);
        int we0;
        we0 = we_cnt;
        if (is_data) begin
            Data_Req_i = 1'b1; Data_Write_i = wr; Data_Addr_i = a; Data_Wdata_i = wd;
        end else begin
            Fetch_Req_i = 1'b1; Fetch_Addr_i = a;
        end
        tick();
        if (!flt) begin
            chk({tag, "_acc_addr"}, Mem_Address_o, a);
            chk({tag, "_acc_we"}, {31'h0, Mem_Write_Enable_o}, {31'h0, wr});
            chk({tag, "_early_ack"}, {30'h0, Fetch_Ack_o, Data_Ack_o}, 32'h0);
            tick();
        end else begin
            chk({tag, "_flt_we"}, {31'h0, Mem_Write_Enable_o}, 32'h0);
        end
        chk({tag, "_ack"}, {30'h0, Fetch_Ack_o, Data_Ack_o}, is_data ? 32'h1 : 32'h2);
        chk({tag, "_fault"}, {31'h0, Fault_o}, {31'h0, flt});
        chk({tag, "_rdata"}, is_data ? Data_Rdata_o : Instruction_o, exp_rd);
        tick();
        Fetch_Req_i = 1'b0; Data_Req_i = 1'b0; Data_Write_i = 1'b0;
        chk({tag, "_ack_1cyc"}, {30'h0, Fetch_Ack_o, Data_Ack_o}, 32'h0);
        chk({tag, "_we_count"}, 32'(we_cnt - we0), (!flt && wr) ? 32'h1 : 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_prev;
        bit found;
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'hC0DE_0000 + 32'(i);
            ram[i] = 32'h5A5A_0000 + 32'(i);
        end
        ram[1] = 32'hDEAD_BEEF;
        ram[3] = 32'h3333_3333;
        reset = 1'b1;
        Fetch_Req_i = 1'b0; Fetch_Addr_i = 32'h0;
        Data_Req_i = 1'b0; Data_Write_i = 1'b0; Data_Addr_i = 32'h0; Data_Wdata_i = 32'h0;
        tick(); tick();
        chk("rst_fack", {31'h0, Fetch_Ack_o}, 32'h0);
        chk("rst_dack", {31'h0, Data_Ack_o}, 32'h0);
        chk("rst_fault", {31'h0, Fault_o}, 32'h0);
        chk("rst_we", {31'h0, Mem_Write_Enable_o}, 32'h0);
        chk("rst_addr", Mem_Address_o, 32'h0);
        chk("rst_wdata", Mem_Write_Data_o, 32'h0);
        chk("rst_instr", Instruction_o, 32'h0);
        chk("rst_rdata", Data_Rdata_o, 32'h0);
        #3 reset = 1'b0;
        tick();

        // Tie out of reset: fetch, then data, then fetch again.
        Fetch_Req_i = 1'b1; Fetch_Addr_i = 32'h0040_0004;
        Data_Req_i = 1'b1; Data_Write_i = 1'b0; Data_Addr_i = 32'h1001_0004;
        tick();
        chk("tie1_addr", Mem_Address_o, 32'h0040_0004);
        tick();
        chk("tie1_ack", {30'h0, Fetch_Ack_o, Data_Ack_o}, 32'h2);
        chk("tie1_instr", Instruction_o, 32'hC0DE_0001);
        tick(); tick();
        chk("tie2_addr", Mem_Address_o, 32'h1001_0004);
        tick();
        chk("tie2_ack", {30'h0, Fetch_Ack_o, Data_Ack_o}, 32'h1);
        chk("tie2_rdata", Data_Rdata_o, 32'hDEAD_BEEF);
        tick(); tick(); tick();
        chk("tie3_ack", {30'h0, Fetch_Ack_o, Data_Ack_o}, 32'h2);
        Fetch_Req_i = 1'b0; Data_Req_i = 1'b0;
        tick(); tick();

        req_op("load1", 1'b1, 1'b0, 32'h1001_0004, 32'h0, 1'b0, 32'hDEAD_BEEF);
        req_op("store2", 1'b1, 1'b1, 32'h1001_0008, 32'h1234_5678, 1'b0, 32'h0);
        chk("store2_ram", ram[2], 32'h1234_5678);
        req_op("load2", 1'b1, 1'b0, 32'h1001_0008, 32'h0, 1'b0, 32'h1234_5678);

        req_op("f_misal", 1'b0, 1'b0, 32'h0040_0002, 32'h0, 1'b1, 32'h0);
        req_op("f_above", 1'b0, 1'b0, 32'h0040_0100, 32'h0, 1'b1, 32'h0);
        req_op("st_rom", 1'b1, 1'b1, 32'h0040_0000, 32'hFFFF_FFFF, 1'b1, 32'h0);

        // Reset dropped on a store while it is in its ACCESS cycle.
        Data_Req_i = 1'b1; Data_Write_i = 1'b1; Data_Addr_i = 32'h1001_000C; Data_Wdata_i = 32'hCAFE_F00D;
        tick();
        chk("rmid_we_on", {31'h0, Mem_Write_Enable_o}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rmid_we_off", {31'h0, Mem_Write_Enable_o}, 32'h0);
        chk("rmid_addr", Mem_Address_o, 32'h0);
        Data_Req_i = 1'b0; Data_Write_i = 1'b0;
        #3 reset = 1'b0;
        tick();
        chk("rmid_noack", {30'h0, Fetch_Ack_o, Data_Ack_o}, 32'h0);
        tick();
        chk("rmid_noack2", {30'h0, Fetch_Ack_o, Data_Ack_o}, 32'h0);
        chk("rmid_ram", ram[3], 32'h3333_3333);
        req_op("post_rst", 1'b0, 1'b0, 32'h0040_0008, 32'h0, 1'b0, 32'hC0DE_0002);

        // Back-to-back fetches with Req held high.
        t_prev = 0;
        Fetch_Req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Fetch_Addr_i = 32'h0040_0000 + 32'(4 * i);
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (Fetch_Ack_o) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("b2b_ack_seen", {31'h0, found}, 32'h1);
            chk("b2b_instr", Instruction_o, 32'hC0DE_0000 + 32'(i));
            if (i > 0) begin
                chk("b2b_spacing", 32'(cyc - t_prev), 32'h3);
            end
            t_prev = cyc;
            tick();
        end
        Fetch_Req_i = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
